// File: rtl/board_move_if.sv
// Board move controller bundle: board snapshot, player buttons and commit outputs.
// The master side drives the board and buttons; the slave side is the controller.
interface board_move_if #(
    parameter int CELLS  = 9,
    parameter int CELL_W = 2,
    parameter int IDX_W  = $clog2(CELLS)
);
    logic [CELLS*CELL_W-1:0] board_in;
    logic [CELL_W-1:0]       player;
    logic                    turn_valid;
    logic                    btn_next_n;
    logic                    btn_place_n;
    logic                    timeout;
    logic [CELLS*CELL_W-1:0] board_out;
    logic                    load;
    logic                    reject;
    logic [IDX_W-1:0]        cursor;
    logic [IDX_W-1:0]        placed_idx;
    logic                    busy;
    logic                    full;

    modport master (
        output board_in, player, turn_valid, btn_next_n, btn_place_n, timeout,
        input  board_out, load, reject, cursor, placed_idx, busy, full
    );

    modport slave (
        input  board_in, player, turn_valid, btn_next_n, btn_place_n, timeout,
        output board_out, load, reject, cursor, placed_idx, busy, full
    );
endinterface

// File: rtl/board_move_ctrl.sv
// Cursor/placement controller with timeout auto-scan for an N-cell board.
// BOARD_MOVE_LFSR_START_EN: auto-scan starts at a pseudo-random cell.
module board_move_ctrl #(
    parameter  int CELLS    = 9,
    parameter  int CELL_W   = 2,
    parameter  int NPLAYERS = 2,
    localparam int IDX_W    = $clog2(CELLS)
) (
    input logic         clk,
    input logic         rst_n,
    board_move_if.slave bm
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CELLS*CELL_W-1:0] r_board;
    logic                    r_load;
    logic                    r_reject;
    logic [IDX_W-1:0]        r_cursor;
    logic [IDX_W-1:0]        r_placed;
    logic [IDX_W-1:0]        r_scan_idx;
    logic [IDX_W-1:0]        r_count;
    logic                    r_next_q;
    logic                    r_place_q;

    logic [CELL_W-1:0]       w_cells [CELLS];
    logic                    w_next_press;
    logic                    w_place_press;
    logic                    w_pvalid;
    logic                    w_full;
    logic [IDX_W-1:0]        w_cursor_inc;
    logic [IDX_W-1:0]        w_scan_inc;
    logic [IDX_W-1:0]        w_start_idx;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [CELLS*CELL_W-1:0] w_board_nxt;
    logic                    w_man_commit;
    logic                    w_man_reject;
    logic                    w_auto_commit;
    logic                    w_start;
    logic                    w_scan_step;
    logic                    w_scan_fail;
    logic                    w_cur_step;

    for (genvar k = 0; k < CELLS; k++) begin : g_cell
        assign w_cells[k] = bm.board_in[k*CELL_W +: CELL_W];
    end

    assign w_next_press  = ~bm.btn_next_n & r_next_q;
    assign w_place_press = ~bm.btn_place_n & r_place_q;
    assign w_pvalid      = (bm.player != '0) &&
                           (bm.player <= CELL_W'(NPLAYERS));
    assign w_cursor_inc  = (r_cursor == IDX_W'(CELLS-1)) ? '0 : r_cursor + 1'b1;
    assign w_scan_inc    = (r_scan_idx == IDX_W'(CELLS-1)) ? '0 : r_scan_idx + 1'b1;
    assign w_wr_idx      = (r_state == S_COMMIT) ? r_scan_idx : r_cursor;

`ifdef BOARD_MOVE_LFSR_START_EN
    logic [7:0] r_lfsr;

    // Galois form of x^8+x^6+x^5+x^4+1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= 8'h01;
        else        r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
    end

    assign w_start_idx = IDX_W'({24'd0, r_lfsr} % CELLS);
`else
    assign w_start_idx = r_cursor;
`endif

    always_comb begin
        w_full = 1'b1;
        for (int k = 0; k < CELLS; k++) begin
            if (w_cells[k] == '0) w_full = 1'b0;
        end
    end

    always_comb begin
        w_board_nxt = bm.board_in;
        w_board_nxt[w_wr_idx*CELL_W +: CELL_W] = bm.player;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_man_commit  = 1'b0;
        w_man_reject  = 1'b0;
        w_auto_commit = 1'b0;
        w_start       = 1'b0;
        w_scan_step   = 1'b0;
        w_scan_fail   = 1'b0;
        w_cur_step    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cur_step = w_next_press;
                // a manual place outranks a pending timeout
                if (w_place_press && bm.turn_valid) begin
                    if (w_pvalid && w_cells[r_cursor] == '0) w_man_commit = 1'b1;
                    else                                     w_man_reject = 1'b1;
                end else if (bm.timeout && bm.turn_valid && w_pvalid) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!bm.turn_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cells[r_scan_idx] == '0) begin
                    w_state_nxt = S_COMMIT;
                end else if (r_count == IDX_W'(CELLS-1)) begin
                    w_scan_fail = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_scan_step = 1'b1;
                end
            end
            S_COMMIT: begin
                w_auto_commit = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_board    <= '0;
            r_load     <= 1'b0;
            r_reject   <= 1'b0;
            r_cursor   <= '0;
            r_placed   <= '0;
            r_scan_idx <= '0;
            r_count    <= '0;
            r_next_q   <= 1'b1;
            r_place_q  <= 1'b1;
        end else begin
            // history tracks even while busy so no stale edge survives a scan
            r_next_q  <= bm.btn_next_n;
            r_place_q <= bm.btn_place_n;
            r_load    <= w_man_commit | w_auto_commit;
            r_reject  <= w_man_reject | w_scan_fail;
            if (w_man_commit || w_auto_commit) begin
                r_board  <= w_board_nxt;
                r_placed <= w_wr_idx;
            end
            if (w_auto_commit)   r_cursor <= r_scan_idx;
            else if (w_cur_step) r_cursor <= w_cursor_inc;
            if (w_start) begin
                r_scan_idx <= w_start_idx;
                r_count    <= '0;
            end else if (w_scan_step) begin
                r_scan_idx <= w_scan_inc;
                r_count    <= r_count + 1'b1;
            end
        end
    end

    assign bm.board_out  = r_board;
    assign bm.load       = r_load;
    assign bm.reject     = r_reject;
    assign bm.cursor     = r_cursor;
    assign bm.placed_idx = r_placed;
    assign bm.busy       = (r_state != S_IDLE);
    assign bm.full       = w_full;
endmodule

// File: tb/tb_board_move_ctrl.sv
// Directed bench for board_move_ctrl (default build, CELLS=9, CELL_W=2).
// Expected values are hand-computed per vector.
module tb_board_move_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    board_move_if #(.CELLS(9), .CELL_W(2)) bm ();

    board_move_ctrl #(.CELLS(9), .CELL_W(2), .NPLAYERS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bm    (bm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_next();
        bm.btn_next_n = 1'b0;
        tick();
        bm.btn_next_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        logic seen;
        bm.board_in    = '0;
        bm.player      = 2'd1;
        bm.turn_valid  = 1'b0;
        bm.btn_next_n  = 1'b1;
        bm.btn_place_n = 1'b1;
        bm.timeout     = 1'b0;
        #12;
        check("rst_board", 32'(bm.board_out), 32'h0);
        check("rst_load", 32'(bm.load), 32'h0);
        check("rst_reject", 32'(bm.reject), 32'h0);
        check("rst_cursor", 32'(bm.cursor), 32'h0);
        check("rst_placed", 32'(bm.placed_idx), 32'h0);
        check("rst_busy", 32'(bm.busy), 32'h0);
        check("rst_full", 32'(bm.full), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // ten held presses: one step each, wrap after 8
        for (int i = 0; i < 10; i++) begin
            bm.btn_next_n = 1'b0;
            repeat (3) tick();
            bm.btn_next_n = 1'b1;
            tick();
            check($sformatf("cursor_%0d", i), 32'(bm.cursor), 32'((i + 1) % 9));
        end

        repeat (3) press_next();
        check("cursor_4", 32'(bm.cursor), 32'd4);

        // manual place on empty board
        bm.turn_valid  = 1'b1;
        bm.btn_place_n = 1'b0;
        tick();
        check("place_load", 32'(bm.load), 32'h1);
        check("place_board", 32'(bm.board_out), 32'h100);
        check("place_idx", 32'(bm.placed_idx), 32'd4);
        check("place_rej", 32'(bm.reject), 32'h0);
        tick();
        check("place_held_load", 32'(bm.load), 32'h0);
        check("place_held_rej", 32'(bm.reject), 32'h0);
        bm.btn_place_n = 1'b1;
        tick();

        // occupied cell
        bm.board_in    = 18'h200;
        bm.btn_place_n = 1'b0;
        tick();
        check("occ_reject", 32'(bm.reject), 32'h1);
        check("occ_load", 32'(bm.load), 32'h0);
        check("occ_board", 32'(bm.board_out), 32'h100);
        bm.btn_place_n = 1'b1;
        tick();
        check("occ_rej_pulse", 32'(bm.reject), 32'h0);

        // invalid player id
        bm.board_in    = '0;
        bm.player      = 2'd3;
        bm.btn_place_n = 1'b0;
        tick();
        check("badp_reject", 32'(bm.reject), 32'h1);
        check("badp_board", 32'(bm.board_out), 32'h100);
        bm.btn_place_n = 1'b1;
        tick();

        // turn not valid: silent
        bm.player      = 2'd1;
        bm.turn_valid  = 1'b0;
        bm.btn_place_n = 1'b0;
        tick();
        check("notv_reject", 32'(bm.reject), 32'h0);
        check("notv_load", 32'(bm.load), 32'h0);
        bm.btn_place_n = 1'b1;
        tick();
        check("notv_board", 32'(bm.board_out), 32'h100);

        // place and next together: place at 4, cursor to 5
        bm.turn_valid  = 1'b1;
        bm.player      = 2'd2;
        bm.btn_place_n = 1'b0;
        bm.btn_next_n  = 1'b0;
        tick();
        check("both_load", 32'(bm.load), 32'h1);
        check("both_board", 32'(bm.board_out), 32'h200);
        check("both_idx", 32'(bm.placed_idx), 32'd4);
        check("both_cursor", 32'(bm.cursor), 32'd5);
        bm.btn_place_n = 1'b1;
        bm.btn_next_n  = 1'b1;
        tick();

        repeat (4) press_next();
        check("cursor_0", 32'(bm.cursor), 32'd0);

        // auto-scan: cells 0..5 owned by 1, player 2 lands on cell 6
        bm.board_in = 18'h00555;
        bm.timeout  = 1'b1;
        tick();
        bm.timeout = 1'b0;
        check("scan_busy_on", 32'(bm.busy), 32'h1);
        n = 0;
        while (!bm.load && n < 20) begin
            if (bm.busy) n++;
            tick();
        end
        check("scan_load", 32'(bm.load), 32'h1);
        check("scan_busy_cycles", 32'(n), 32'd8);
        check("scan_board", 32'(bm.board_out), 32'h2555);
        check("scan_cursor", 32'(bm.cursor), 32'd6);
        check("scan_placed", 32'(bm.placed_idx), 32'd6);
        check("scan_busy_off", 32'(bm.busy), 32'h0);
        check("scan_rej", 32'(bm.reject), 32'h0);

        // full board: CELLS scan cycles then reject
        tick();
        bm.board_in = 18'h15555;
        bm.player   = 2'd1;
        #1;
        check("full_flag", 32'(bm.full), 32'h1);
        bm.timeout = 1'b1;
        tick();
        bm.timeout = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (bm.busy && n < 30) begin
            n++;
            if (bm.load) seen = 1'b1;
            tick();
        end
        check("full_busy_cycles", 32'(n), 32'd9);
        check("full_reject", 32'(bm.reject), 32'h1);
        check("full_load", 32'(bm.load | seen), 32'h0);
        check("full_board", 32'(bm.board_out), 32'h2555);
        tick();

        // turn_valid drops mid-scan: abort silently
        bm.board_in = 18'h05555;
        bm.timeout  = 1'b1;
        tick();
        bm.timeout = 1'b0;
        tick();
        bm.turn_valid = 1'b0;
        tick();
        check("abort_busy", 32'(bm.busy), 32'h0);
        seen = 1'b0;
        repeat (3) begin
            if (bm.load || bm.reject) seen = 1'b1;
            tick();
        end
        check("abort_quiet", 32'(seen), 32'h0);
        check("abort_board", 32'(bm.board_out), 32'h2555);

        // reset in the middle of a scan
        bm.turn_valid = 1'b1;
        bm.timeout    = 1'b1;
        tick();
        bm.timeout = 1'b0;
        tick();
        check("mid_busy", 32'(bm.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_board", 32'(bm.board_out), 32'h0);
        check("mid_rst_cursor", 32'(bm.cursor), 32'h0);
        check("mid_rst_placed", 32'(bm.placed_idx), 32'h0);
        check("mid_rst_busy", 32'(bm.busy), 32'h0);
        check("mid_rst_load", 32'(bm.load), 32'h0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            if (bm.load || bm.busy) seen = 1'b1;
            tick();
        end
        check("mid_no_load", 32'(seen), 32'h0);
        check("mid_board", 32'(bm.board_out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
